// File: rtl/serial_sbc32_pkg.sv
// Shared definitions for the bit-serial subtract-with-borrow block and its bench.
package serial_sbc32_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of RUN cycles needed to walk the whole word for a given slice width.
    function automatic int slice_count(input int slice);
        return DATA_W / slice;
    endfunction

endpackage

// File: rtl/serial_sbc32_slice.sv
// Combinational SLICE-bit subtract-with-borrow cell.
module sbc_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             bi,
    output logic [SLICE-1:0] d,
    output logic             bo
);

    // One extra bit of width: a negative result wraps and sets the top bit,
    // which is exactly the borrow-out.
    always_comb begin
        {bo, d} = {1'b0, a} - {1'b0, b} - {{SLICE{1'b0}}, bi};
    end

endmodule

// File: rtl/serial_sbc32.sv
// Bit-serial 32-bit subtractor with borrow: D = A - B - Bi, SLICE bits per cycle.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; D/Bo hold the last result
// RUN   | one slice per cycle, LSB slice first; busy high
// DONE  | single cycle with done high and D/Bo final; start re-arms
module serial_sbc32
    import serial_sbc32_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              Bi,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] D,
    output logic              Bo
);

    localparam int N     = slice_count(SLICE);
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int POS_W = 6;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] a_q, b_q, d_q;
    logic              borrow_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              accept;
    logic [POS_W-1:0]  bit_pos;
    logic [DATA_W-1:0] a_sh, b_sh;
    logic [SLICE-1:0]  slice_d;
    logic              slice_bo;
    logic [DATA_W-1:0] slice_mask;
    logic [DATA_W-1:0] d_next;

    // Start is only honoured outside RUN, so a mid-operation start cannot
    // disturb captured operands.
    assign accept  = start && (state_q != RUN);
    assign bit_pos = POS_W'(cnt_q) * POS_W'(SLICE);
    assign a_sh    = a_q >> bit_pos;
    assign b_sh    = b_q >> bit_pos;

    sbc_slice #(
        .SLICE(SLICE)
    ) u_slice (
        .a  (a_sh[SLICE-1:0]),
        .b  (b_sh[SLICE-1:0]),
        .bi (borrow_q),
        .d  (slice_d),
        .bo (slice_bo)
    );

    // Merge the current slice result into the difference word at its position.
    always_comb begin
        slice_mask = DATA_W'({SLICE{1'b1}}) << bit_pos;
        d_next     = (d_q & ~slice_mask) | (DATA_W'(slice_d) << bit_pos);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt_q == CNT_LAST) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = start ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, slice counter, running borrow and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            d_q      <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else if (accept) begin
            a_q      <= A;
            b_q      <= B;
            borrow_q <= Bi;
            cnt_q    <= '0;
        end else if (state_q == RUN) begin
            d_q      <= d_next;
            borrow_q <= slice_bo;
            if (cnt_q != CNT_LAST) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign D  = d_q;
    assign Bo = borrow_q;

endmodule

// File: tb/tb_serial_sbc32.sv
// Scoreboard bench: three instances (SLICE = 4, 1, 32) share one stimulus stream.
module tb_serial_sbc32;
    import serial_sbc32_pkg::*;

    localparam int NI = 3;
    localparam int SLV [NI] = '{4, 1, 32};
    localparam int NV  [NI] = '{8, 32, 1};

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              bo;
        int                due;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [DATA_W-1:0] a_in = '0;
    logic [DATA_W-1:0] b_in = '0;
    logic              bi_in = 1'b0;

    logic              busy_w [NI];
    logic              done_w [NI];
    logic [DATA_W-1:0] d_w    [NI];
    logic              bo_w   [NI];

    exp_t              q      [NI][$];
    int                ph     [NI];
    logic [DATA_W-1:0] last_d [NI];
    logic              last_bo[NI];
    int                cyc = 0;
    int                checks = 0;
    int                failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        serial_sbc32 #(
            .SLICE(SLV[g])
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .start (start),
            .A     (a_in),
            .B     (b_in),
            .Bi    (bi_in),
            .busy  (busy_w[g]),
            .done  (done_w[g]),
            .D     (d_w[g]),
            .Bo    (bo_w[g])
        );
    end

    function automatic exp_t ref_result(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                        input logic bi, input int due);
        exp_t e;
        longint unsigned av = a;
        longint unsigned bv = b;
        e.d   = DATA_W'(av - bv - longint'(bi));
        e.bo  = (av < bv + longint'(bi));
        e.due = due;
        return e;
    endfunction

    task automatic chk(input string name, input int inst, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s slice=%0d t=%0t got=%h expected=%h", name, SLV[inst], $time, act, exp);
        end
    endtask

    // Reference model: timing of accept / run / done per instance, expected results queued.
    initial begin
        for (int i = 0; i < NI; i++) begin
            ph[i] = 0; last_d[i] = '0; last_bo[i] = 1'b0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < NI; i++) begin
                    ph[i] = 0; q[i].delete(); last_d[i] = '0; last_bo[i] = 1'b0;
                end
            end else begin
                cyc++;
                for (int i = 0; i < NI; i++) begin
                    if (ph[i] == 0 || ph[i] == NV[i] + 1) begin
                        if (start) begin
                            q[i].push_back(ref_result(a_in, b_in, bi_in, cyc + NV[i]));
                            ph[i] = 1;
                        end else begin
                            ph[i] = 0;
                        end
                    end else if (ph[i] == NV[i]) begin
                        ph[i] = NV[i] + 1;
                    end else begin
                        ph[i] = ph[i] + 1;
                    end
                end
            end
        end
    end

    // Monitor: status every cycle, results popped whenever done is presented.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                chk("busy", i, DATA_W'(busy_w[i]), DATA_W'(ph[i] >= 1 && ph[i] <= NV[i]));
                chk("done", i, DATA_W'(done_w[i]), DATA_W'(ph[i] == NV[i] + 1));
                if (done_w[i] === 1'b1) begin
                    if (q[i].size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_done slice=%0d t=%0t got=done expected=no_done", SLV[i], $time);
                    end else begin
                        e = q[i].pop_front();
                        chk("D", i, d_w[i], e.d);
                        chk("Bo", i, DATA_W'(bo_w[i]), DATA_W'(e.bo));
                        chk("latency", i, DATA_W'(cyc), DATA_W'(e.due));
                        last_d[i]  = e.d;
                        last_bo[i] = e.bo;
                    end
                end else if (ph[i] == 0) begin
                    chk("D_hold", i, d_w[i], last_d[i]);
                    chk("Bo_hold", i, DATA_W'(bo_w[i]), DATA_W'(last_bo[i]));
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!(ph[0] == 0 && ph[1] == 0 && ph[2] == 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            failures++;
            $display("FAIL idle_timeout got=busy expected=idle");
        end
    endtask

    task automatic op(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input logic bi);
        @(negedge clk);
        start = 1'b1; a_in = a; b_in = b; bi_in = bi;
        @(negedge clk);
        start = 1'b0; a_in = $urandom; b_in = $urandom; bi_in = 1'($urandom);
        wait_idle();
    endtask

    task automatic pulse_reset(input int len);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("rst_busy", i, DATA_W'(busy_w[i]), '0);
            chk("rst_done", i, DATA_W'(done_w[i]), '0);
            chk("rst_D", i, d_w[i], '0);
            chk("rst_Bo", i, DATA_W'(bo_w[i]), '0);
        end
        repeat (len) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("rst_D_init", i, d_w[i], '0);
            chk("rst_busy_init", i, DATA_W'(busy_w[i]), '0);
        end
        #2 rst_n = 1'b1;

        op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        op(32'h0000_0000, 32'h0000_0001, 1'b0);
        op(32'h8000_0000, 32'h0000_0001, 1'b0);
        op(32'h0000_0000, 32'h0000_0000, 1'b1);
        op(32'h1234_5678, 32'h1234_5678, 1'b0);

        for (int k = 0; k < 20; k++) begin
            op($urandom, $urandom, 1'($urandom));
        end

        // Start held high: back-to-back operations with operands changing every cycle.
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < 80; k++) begin
            a_in = $urandom; b_in = $urandom; bi_in = 1'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        wait_idle();

        // Second start pulse while the wider-latency instances are still running.
        @(negedge clk);
        start = 1'b1; a_in = 32'hDEAD_BEEF; b_in = 32'h0BAD_F00D; bi_in = 1'b1;
        @(negedge clk);
        start = 1'b0; a_in = '0; b_in = '1; bi_in = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; a_in = 32'h0000_0005; b_in = 32'h0000_0009; bi_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Reset in the middle of RUN, then a fresh operation.
        @(negedge clk);
        start = 1'b1; a_in = 32'hCAFE_0000; b_in = 32'h0000_CAFE; bi_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        pulse_reset(2);
        op(32'h8000_0000, 32'h0000_0001, 1'b0);
        op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);

        repeat (5) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("queue_drained", i, DATA_W'(q[i].size()), '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
